// File: rtl/tlc_ped_walk.sv
`default_nettype none
// ==================================================================
// tlc_ped_walk : pedestrian WALK / DON'T-WALK stage behind the TLC
// Optional chirp output enabled by TLC_PED_CHIRP_EN.     Rev 1.0
// ==================================================================
module tlc_ped_walk #(
  parameter int FLASH_AT  = 4,
  parameter int BLINK_DIV = 5,
  parameter int CHIRP_DIV = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] ps_state,
  input  logic [3:0] count,
  input  logic       ped_btn,
  output logic       walk,
  output logic       dont_walk,
  output logic       req_pending,
`ifdef TLC_PED_CHIRP_EN
  output logic       chirp,
`endif
  output logic [6:0] seg
);

  localparam int c_DIV_MAX = (BLINK_DIV > CHIRP_DIV) ? BLINK_DIV : CHIRP_DIV;
  localparam int c_CNT_W   = $clog2(c_DIV_MAX) + 1;

  localparam logic [c_CNT_W-1:0] c_BLINK_LAST = c_CNT_W'(BLINK_DIV - 1);
  localparam logic [3:0]         c_FLASH_AT   = 4'(FLASH_AT);
  localparam logic [1:0]         c_EW_GREEN   = 2'b10;
  localparam logic [6:0]         c_BLANK      = 7'h7F;

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_ARMED = 2'd1;
  localparam logic [1:0] c_WALK  = 2'd2;
  localparam logic [1:0] c_FLASH = 2'd3;

  logic [1:0]         r_state, w_state_n;
  logic               r_btn_s1, r_btn_s2, r_btn_d;
  logic [1:0]         r_ps_q;
  logic               r_req;
  logic               r_walk, w_walk_n;
  logic               r_dont_walk, w_dont_walk_n;
  logic [6:0]         r_seg, w_seg_n, w_digit;
  logic [c_CNT_W-1:0] r_blink_cnt, w_blink_cnt_n;
  logic               r_blink_ph, w_blink_ph_n;
  logic [3:0]         w_cnt_sat;
  logic               w_ew_green, w_ew_entry, w_req_edge, w_grant, w_req_n;

  assign w_ew_green = (ps_state == c_EW_GREEN);
  assign w_ew_entry = w_ew_green && (r_ps_q != c_EW_GREEN);
  assign w_req_edge = r_btn_s2 & ~r_btn_d;
  assign w_grant    = (r_state == c_ARMED) && w_ew_entry;
  assign w_req_n    = r_req | w_req_edge;

  // Synchroniser, phase history and request latch (a new edge beats a grant).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_btn_s1 <= 1'b0;
      r_btn_s2 <= 1'b0;
      r_btn_d  <= 1'b0;
      r_ps_q   <= 2'b00;
      r_req    <= 1'b0;
    end else begin
      r_btn_s1 <= ped_btn;
      r_btn_s2 <= r_btn_s1;
      r_btn_d  <= r_btn_s2;
      r_ps_q   <= ps_state;
      if (w_req_edge)   r_req <= 1'b1;
      else if (w_grant) r_req <= 1'b0;
    end
  end

`ifdef TLC_PED_CHIRP_EN
  localparam logic [c_CNT_W-1:0] c_CHIRP_LAST = c_CNT_W'(CHIRP_DIV - 1);
  logic [c_CNT_W-1:0] r_chirp_cnt, w_chirp_cnt_n;
  logic               r_chirp, w_chirp_n;
  assign chirp = r_chirp;
`endif

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= c_IDLE;
      r_walk      <= 1'b0;
      r_dont_walk <= 1'b1;
      r_seg       <= c_BLANK;
      r_blink_cnt <= '0;
      r_blink_ph  <= 1'b0;
`ifdef TLC_PED_CHIRP_EN
      r_chirp_cnt <= '0;
      r_chirp     <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_n;
      r_walk      <= w_walk_n;
      r_dont_walk <= w_dont_walk_n;
      r_seg       <= w_seg_n;
      r_blink_cnt <= w_blink_cnt_n;
      r_blink_ph  <= w_blink_ph_n;
`ifdef TLC_PED_CHIRP_EN
      r_chirp_cnt <= w_chirp_cnt_n;
      r_chirp     <= w_chirp_n;
`endif
    end
  end

  // Leaving EW-green always wins over the flash threshold.
  always_comb begin
    w_state_n = r_state;
    case (r_state)
      c_IDLE:  if (w_req_edge) w_state_n = c_ARMED;
      c_ARMED: if (w_ew_entry) w_state_n = c_WALK;
      c_WALK: begin
        if (!w_ew_green)              w_state_n = w_req_n ? c_ARMED : c_IDLE;
        else if (count <= c_FLASH_AT) w_state_n = c_FLASH;
      end
      c_FLASH: if (!w_ew_green) w_state_n = w_req_n ? c_ARMED : c_IDLE;
      default: w_state_n = c_IDLE;
    endcase
  end

  assign w_cnt_sat = (count > 4'd9) ? 4'd9 : count;

  always_comb begin
    w_digit = 7'h10;
    case (w_cnt_sat)
      4'd0:    w_digit = 7'h40;
      4'd1:    w_digit = 7'h79;
      4'd2:    w_digit = 7'h24;
      4'd3:    w_digit = 7'h30;
      4'd4:    w_digit = 7'h19;
      4'd5:    w_digit = 7'h12;
      4'd6:    w_digit = 7'h02;
      4'd7:    w_digit = 7'h78;
      4'd8:    w_digit = 7'h00;
      default: w_digit = 7'h10;
    endcase
  end

  always_comb begin
    w_walk_n      = (w_state_n == c_WALK);
    w_dont_walk_n = 1'b1;
    w_blink_cnt_n = '0;
    w_blink_ph_n  = 1'b0;
    w_seg_n       = c_BLANK;
    if (w_state_n == c_FLASH) begin
      // Blink phase 0 shows the lamp lit; a fresh FLASH always starts lit.
      if (r_state != c_FLASH) begin
        w_blink_cnt_n = '0;
        w_blink_ph_n  = 1'b0;
      end else if (r_blink_cnt == c_BLINK_LAST) begin
        w_blink_cnt_n = '0;
        w_blink_ph_n  = ~r_blink_ph;
      end else begin
        w_blink_cnt_n = r_blink_cnt + 1'b1;
        w_blink_ph_n  = r_blink_ph;
      end
      w_dont_walk_n = ~w_blink_ph_n;
      w_seg_n       = w_digit;
    end else if (w_state_n == c_WALK) begin
      w_dont_walk_n = 1'b0;
      w_seg_n       = w_digit;
    end
  end

`ifdef TLC_PED_CHIRP_EN
  always_comb begin
    w_chirp_cnt_n = '0;
    w_chirp_n     = 1'b0;
    if (w_state_n == c_WALK) begin
      if (r_state != c_WALK) begin
        w_chirp_cnt_n = '0;
        w_chirp_n     = 1'b0;
      end else if (r_chirp_cnt == c_CHIRP_LAST) begin
        w_chirp_cnt_n = '0;
        w_chirp_n     = ~r_chirp;
      end else begin
        w_chirp_cnt_n = r_chirp_cnt + 1'b1;
        w_chirp_n     = r_chirp;
      end
    end else if (w_state_n == c_FLASH) begin
      w_chirp_n = (r_state == c_FLASH) && r_blink_ph && !w_blink_ph_n;
    end
  end
`endif

  assign walk        = r_walk & w_ew_green;
  assign dont_walk   = r_dont_walk;
  assign req_pending = r_req;
  assign seg         = r_seg;

endmodule
`default_nettype wire

// File: tb/tb_tlc_ped_walk.sv
`default_nettype none
// ==================================================================
// tb_tlc_ped_walk : vector table, corner sequences and random TLC run
// Rev 1.0
// ==================================================================
module tb_tlc_ped_walk;

  localparam int P_FLASH_AT  = 4;
  localparam int P_BLINK_DIV = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] ps_state;
  logic [3:0] count;
  logic       ped_btn;
  logic       walk, dont_walk, req_pending;
  logic [6:0] seg;
`ifdef TLC_PED_CHIRP_EN
  logic       chirp;
`endif

  tlc_ped_walk #(.FLASH_AT(P_FLASH_AT), .BLINK_DIV(P_BLINK_DIV), .CHIRP_DIV(2)) dut (
    .clk(clk), .rst(rst), .ps_state(ps_state), .count(count), .ped_btn(ped_btn),
    .walk(walk), .dont_walk(dont_walk), .req_pending(req_pending),
`ifdef TLC_PED_CHIRP_EN
    .chirp(chirp),
`endif
    .seg(seg)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input int v);
    case (v)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  default: return 7'h10;
    endcase
  endfunction

  // Reference model: a request is waiting, being served (walk, then flash), or absent.
  bit         m_req, m_waiting, m_active;
  int         m_flash_age;
  logic [1:0] m_prev_ps;
  logic [6:0] m_seg;
  bit         hist[$];

  function automatic void model_reset();
    m_req = 0; m_waiting = 0; m_active = 0; m_flash_age = -1;
    m_prev_ps = 2'b00; m_seg = 7'h7F;
    hist.delete();
    for (int i = 0; i < 3; i++) hist.push_back(1'b0);
  endfunction

  function automatic void model_step();
    bit edge_seen, ew, green, grant;
    int c;
    c         = int'(count);
    edge_seen = hist[1] && !hist[0];
    green     = (ps_state == 2'b10);
    ew        = green && (m_prev_ps != 2'b10);
    grant     = 0;
    if (m_active) begin
      if (!green) begin
        m_active  = 0;
        m_waiting = m_req || edge_seen;
      end else if (m_flash_age >= 0) begin
        m_flash_age++;
      end else if (c <= P_FLASH_AT) begin
        m_flash_age = 0;
      end
    end else if (m_waiting) begin
      if (ew) begin
        m_active = 1; m_waiting = 0; m_flash_age = -1; grant = 1;
      end
    end else if (edge_seen) begin
      m_waiting = 1;
    end
    if (edge_seen) m_req = 1;
    else if (grant) m_req = 0;
    m_seg = m_active ? seg_of((c > 9) ? 9 : c) : 7'h7F;
    hist.push_back(ped_btn);
    void'(hist.pop_front());
    m_prev_ps = ps_state;
  endfunction

  task automatic clk_edge();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic check_model(input string tag);
    bit ew_walk, ew_dw;
    ew_walk = m_active && (m_flash_age < 0) && (ps_state == 2'b10);
    ew_dw   = !m_active ? 1'b1 : (m_flash_age < 0) ? 1'b0 : (((m_flash_age / P_BLINK_DIV) % 2) == 0);
    chk({tag, "_walk"}, 7'(walk), 7'(ew_walk));
    chk({tag, "_dw"},   7'(dont_walk), 7'(ew_dw));
    chk({tag, "_req"},  7'(req_pending), 7'(m_req));
    chk({tag, "_seg"},  seg, m_seg);
  endtask

  task automatic step(input string tag, input logic [1:0] p, input logic [3:0] c, input logic b);
    ps_state = p; count = c; ped_btn = b;
    clk_edge();
    check_model(tag);
  endtask

  typedef struct {
    logic [1:0] ps;
    logic [3:0] cnt;
    logic       btn;
    logic       w;
    logic       dw;
    logic       req;
    logic [6:0] sg;
  } vec_t;

  vec_t vt [22];

  initial begin
    vt = '{
      '{2'd0, 4'd15, 1'b1, 1'b0, 1'b1, 1'b0, 7'h7F},
      '{2'd0, 4'd14, 1'b0, 1'b0, 1'b1, 1'b0, 7'h7F},
      '{2'd0, 4'd13, 1'b0, 1'b0, 1'b1, 1'b1, 7'h7F},
      '{2'd1, 4'd3,  1'b0, 1'b0, 1'b1, 1'b1, 7'h7F},
      '{2'd1, 4'd2,  1'b0, 1'b0, 1'b1, 1'b1, 7'h7F},
      '{2'd2, 4'd15, 1'b0, 1'b1, 1'b0, 1'b0, 7'h10},
      '{2'd2, 4'd14, 1'b0, 1'b1, 1'b0, 1'b0, 7'h10},
      '{2'd2, 4'd9,  1'b0, 1'b1, 1'b0, 1'b0, 7'h10},
      '{2'd2, 4'd7,  1'b0, 1'b1, 1'b0, 1'b0, 7'h78},
      '{2'd2, 4'd5,  1'b0, 1'b1, 1'b0, 1'b0, 7'h12},
      '{2'd2, 4'd4,  1'b0, 1'b0, 1'b1, 1'b0, 7'h19},
      '{2'd2, 4'd3,  1'b0, 1'b0, 1'b1, 1'b0, 7'h30},
      '{2'd2, 4'd2,  1'b0, 1'b0, 1'b1, 1'b0, 7'h24},
      '{2'd2, 4'd1,  1'b0, 1'b0, 1'b1, 1'b0, 7'h79},
      '{2'd2, 4'd0,  1'b0, 1'b0, 1'b1, 1'b0, 7'h40},
      '{2'd2, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 7'h40},
      '{2'd2, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 7'h40},
      '{2'd2, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 7'h40},
      '{2'd2, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 7'h40},
      '{2'd2, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 7'h40},
      '{2'd2, 4'd0,  1'b0, 1'b0, 1'b1, 1'b0, 7'h40},
      '{2'd3, 4'd3,  1'b0, 1'b0, 1'b1, 1'b0, 7'h7F}
    };

    rst = 1'b1; ps_state = 2'b00; count = 4'd15; ped_btn = 1'b0;
    model_reset();
    #10 rst = 1'b0;
    #1;
    chk("rst_walk", 7'(walk), 7'd0);
    chk("rst_dw",   7'(dont_walk), 7'd1);
    chk("rst_req",  7'(req_pending), 7'd0);
    chk("rst_seg",  seg, 7'h7F);
    for (int i = 0; i < 20; i++) step("idle", 2'b00, 4'd15, 1'b0);

    // Basic grant through flash and back to blank
    for (int i = 0; i < 22; i++) begin
      ps_state = vt[i].ps; count = vt[i].cnt; ped_btn = vt[i].btn;
      clk_edge();
      chk($sformatf("vec%0d_walk", i), 7'(walk), 7'(vt[i].w));
      chk($sformatf("vec%0d_dw", i),   7'(dont_walk), 7'(vt[i].dw));
      chk($sformatf("vec%0d_req", i),  7'(req_pending), 7'(vt[i].req));
      chk($sformatf("vec%0d_seg", i),  seg, vt[i].sg);
    end

    // Request made inside EW-green must wait for the next entry
    step("late", 2'b00, 4'd5, 1'b0);
    step("late", 2'b01, 4'd2, 1'b0);
    step("late", 2'b10, 4'd15, 1'b0);
    step("late", 2'b10, 4'd8, 1'b1);
    for (int c = 7; c >= 0; c--) begin
      step("late", 2'b10, 4'(c), 1'b0);
      chk("late_nowalk", 7'(walk), 7'd0);
    end
    chk("late_req", 7'(req_pending), 7'd1);
    step("late", 2'b11, 4'd3, 1'b0);
    step("late", 2'b00, 4'd5, 1'b0);
    step("late", 2'b01, 4'd2, 1'b0);
    step("late", 2'b10, 4'd15, 1'b0);
    chk("late_grant_walk", 7'(walk), 7'd1);
    chk("late_grant_req",  7'(req_pending), 7'd0);

    // Abort: leaving EW-green gates walk before the next edge
    step("abort", 2'b10, 4'd14, 1'b0);
    step("abort", 2'b10, 4'd12, 1'b0);
    ps_state = 2'b11;
    #1;
    chk("abort_gate", 7'(walk), 7'd0);
    step("abort", 2'b11, 4'd11, 1'b0);
    chk("abort_dw",  7'(dont_walk), 7'd1);
    chk("abort_seg", seg, 7'h7F);

    // Asynchronous reset in the middle of WALK
    step("rmw", 2'b00, 4'd5, 1'b1);
    step("rmw", 2'b00, 4'd4, 1'b0);
    step("rmw", 2'b00, 4'd3, 1'b0);
    step("rmw", 2'b00, 4'd2, 1'b0);
    step("rmw", 2'b01, 4'd2, 1'b0);
    for (int c = 15; c >= 10; c--) step("rmw", 2'b10, 4'(c), 1'b0);
    chk("rmw_pre_walk", 7'(walk), 7'd1);
    #2 rst = 1'b1;
    #1;
    chk("rmw_walk", 7'(walk), 7'd0);
    chk("rmw_dw",   7'(dont_walk), 7'd1);
    chk("rmw_req",  7'(req_pending), 7'd0);
    chk("rmw_seg",  seg, 7'h7F);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;

    // Random TLC phase sequence with random button activity and early aborts
    begin
      logic [1:0] p;
      logic [3:0] c;
      int hold;
      logic b;
      p = 2'b00; c = 4'(8); hold = 0;
      for (int i = 0; i < 900; i++) begin
        if (hold > 0) begin
          b = 1'b1; hold--;
        end else if ($urandom_range(0, 11) == 0) begin
          b = 1'b1; hold = $urandom_range(0, 3);
        end else begin
          b = 1'b0;
        end
        step("rnd", p, c, b);
        if (p == 2'b10 && $urandom_range(0, 24) == 0) begin
          p = 2'b11; c = 4'($urandom_range(2, 4));
        end else if (c == 4'd0) begin
          p = p + 2'b01;
          c = 4'($urandom_range(5, 15));
        end else begin
          c = c - 4'd1;
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
